// File: rtl/spi_slave_if.sv
// Register-bus bundle shared with the SPI controller peripheral.
// The slave modport is the peripheral side; master is the bus/firmware side.
interface spi_slave_if;
    logic [7:0]  waddr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [7:0]  raddr_i;
    logic        rd_i;
    logic [31:0] data_o;

    modport slave  (input  waddr_i, data_i, sel_i, we_i, raddr_i, rd_i,
                    output data_o);
    modport master (output waddr_i, data_i, sel_i, we_i, raddr_i, rd_i,
                    input  data_o);
endinterface

// File: rtl/spi_slave.sv
// Memory-mapped SPI target: oversamples SCLK/CS/MOSI on clk, receives bytes into
// RXDATA and shifts out a one-deep TXDATA buffer on MISO, all four CPOL/CPHA modes.
module spi_slave #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] UNDERRUN_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  bus,
    input  logic        spi_clk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq_spi_rx
);
    localparam logic [7:0] UNDERRUN_VAL = UNDERRUN_BYTE;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic       r_sclk_prev;
    logic       r_en, r_cpol, r_cpha, r_irq_en;
    logic [7:0] r_tx_buf, r_tx_shift, r_rx_shift, r_rx_data;
    logic       r_tx_full, r_rx_valid, r_rx_overrun, r_tx_underrun;
    logic       r_in_byte, r_irq;
    logic [2:0] r_bit_cnt;
    logic [31:0] r_data_o;

    logic w_sclk_s, w_cs_s, w_mosi_s, w_active;
    logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
    logic w_load, w_do_sample, w_complete, w_end_cpha0;
    logic w_wr, w_ctrl_wr, w_tx_wr, w_stat_wr, w_rx_rd;
    logic [7:0]  w_rx_next;
    logic [31:0] w_rdata;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    // Outside an enabled, selected frame everything is held idle; this doubles as CS-abort.
    assign w_active = r_en & ~w_cs_s;

    assign w_rise   = w_sclk_s & ~r_sclk_prev;
    assign w_fall   = ~w_sclk_s & r_sclk_prev;
    assign w_lead   = r_cpol ? w_fall : w_rise;
    assign w_trail  = r_cpol ? w_rise : w_fall;
    assign w_sample = w_active & (r_cpha ? w_trail : w_lead);
    assign w_shift  = w_active & (r_cpha ? w_lead : w_trail);

    assign w_load      = ~r_in_byte & (r_cpha ? w_shift : w_sample);
    assign w_do_sample = w_sample & (r_in_byte | w_load);
    assign w_complete  = w_do_sample & (r_bit_cnt == 3'd7);
    // CPHA=0 keeps in_byte through completion; bit_cnt==0 while in_byte marks that wait.
    assign w_end_cpha0 = ~r_cpha & r_in_byte & (r_bit_cnt == 3'd0);
    assign w_rx_next   = {r_rx_shift[6:0], w_mosi_s};

    assign w_wr      = bus.we_i & bus.sel_i[0];
    assign w_ctrl_wr = w_wr & (bus.waddr_i[3:0] == 4'h0);
    assign w_tx_wr   = w_wr & (bus.waddr_i[3:0] == 4'h4);
    assign w_stat_wr = w_wr & (bus.waddr_i[3:0] == 4'hC);
    assign w_rx_rd   = bus.rd_i & (bus.raddr_i[3:0] == 4'h8);

    always_comb begin
        w_rdata = 32'h0;
        case (bus.raddr_i[3:0])
            4'h0: w_rdata = {28'h0, r_irq_en, r_cpha, r_cpol, r_en};
            4'h4: w_rdata = {24'h0, r_tx_buf};
            4'h8: w_rdata = {24'h0, r_rx_data};
            4'hC: w_rdata = {27'h0, r_tx_underrun, r_rx_overrun, r_tx_full,
                             r_rx_valid, w_active};
            default: w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync   <= '0;
            r_cs_sync     <= '1;
            r_mosi_sync   <= '0;
            r_sclk_prev   <= 1'b0;
            r_en          <= 1'b0;
            r_cpol        <= 1'b0;
            r_cpha        <= 1'b0;
            r_irq_en      <= 1'b0;
            r_tx_buf      <= 8'h0;
            r_tx_shift    <= 8'h0;
            r_rx_shift    <= 8'h0;
            r_rx_data     <= 8'h0;
            r_tx_full     <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_in_byte     <= 1'b0;
            r_bit_cnt     <= 3'd0;
            r_irq         <= 1'b0;
            r_data_o      <= 32'h0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_prev <= w_sclk_s;
            r_irq       <= w_complete & r_irq_en;

            if (w_ctrl_wr)
                {r_irq_en, r_cpha, r_cpol, r_en} <= bus.data_i[3:0];

            if (!w_active) begin
                r_in_byte  <= 1'b0;
                r_bit_cnt  <= 3'd0;
                r_rx_shift <= 8'h0;
            end else begin
                if (w_load) begin
                    r_tx_shift <= r_tx_full ? r_tx_buf : UNDERRUN_BYTE;
                    r_in_byte  <= 1'b1;
                end else if (w_shift & r_in_byte) begin
                    if (w_end_cpha0)
                        r_in_byte <= 1'b0;
                    else
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
                if (w_do_sample) begin
                    r_rx_shift <= w_rx_next;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (w_complete && r_cpha)
                        r_in_byte <= 1'b0;
                end
            end

            // A TXDATA write beats a same-cycle load; the load still takes the old byte.
            if (w_tx_wr) begin
                r_tx_buf  <= bus.data_i[7:0];
                r_tx_full <= 1'b1;
            end else if (w_load && r_tx_full) begin
                r_tx_full <= 1'b0;
            end

            if (w_load && !r_tx_full)
                r_tx_underrun <= 1'b1;
            else if (w_stat_wr && bus.data_i[4])
                r_tx_underrun <= 1'b0;

            if (w_complete)
                r_rx_data <= w_rx_next;

            if (w_complete)
                r_rx_valid <= 1'b1;
            else if (w_rx_rd)
                r_rx_valid <= 1'b0;

            if (w_complete && r_rx_valid && !w_rx_rd)
                r_rx_overrun <= 1'b1;
            else if (w_stat_wr && bus.data_i[3])
                r_rx_overrun <= 1'b0;

            if (bus.rd_i)
                r_data_o <= w_rdata;
        end
    end

    assign bus.data_o  = r_data_o;
    assign irq_spi_rx  = r_irq;
    assign spi_miso_oe = w_active;
    // Before a byte starts, present bit 7 of what will be loaded so CPHA=0 masters see it.
    assign spi_miso    = r_in_byte ? r_tx_shift[7]
                                   : (r_tx_full ? r_tx_buf[7] : UNDERRUN_VAL[7]);
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master plus firmware-style
// register accesses, with expected MISO/RXDATA bytes queued as each byte is driven.
`timescale 1ns/1ps
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic spi_miso, spi_miso_oe, irq_spi_rx;
    logic m_cpol = 1'b0, m_cpha = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int irq_cnt = 0;
    logic [7:0] miso_q[$];
    logic [7:0] rx_q[$];

    spi_slave_if bus ();

    spi_slave #(.SYNC_STAGES(2), .UNDERRUN_BYTE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_clk(sclk), .spi_cs(cs), .spi_mosi(mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq_spi_rx(irq_spi_rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (irq_spi_rx) irq_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.waddr_i = {4'h0, a}; bus.data_i = d; bus.sel_i = 4'h1; bus.we_i = 1'b1;
        @(posedge clk); #1;
        bus.we_i = 1'b0; bus.sel_i = 4'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.raddr_i = {4'h0, a}; bus.rd_i = 1'b1;
        @(posedge clk); #1;
        bus.rd_i = 1'b0;
        d = bus.data_o;
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        m_cpol = cpol; m_cpha = cpha; sclk = cpol;
        tick(6);
    endtask

    task automatic cs_low();  cs = 1'b0; tick(6); endtask
    task automatic cs_high(); tick(2); cs = 1'b1; tick(6); endtask

    // Master: half period of 6 clk; CPHA=0 samples on leading edges, CPHA=1 on trailing.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!m_cpha) begin
                mosi = mo[i]; tick(6);
                mi[i] = spi_miso; sclk = ~m_cpol; tick(6);
                sclk = m_cpol;
            end else begin
                sclk = ~m_cpol; mosi = mo[i]; tick(6);
                mi[i] = spi_miso; sclk = m_cpol; tick(6);
            end
        end
        tick(4);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        tick(3);
        vectors++;
        if ({spi_miso, spi_miso_oe, irq_spi_rx} !== 3'b000 || bus.data_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got miso=%b oe=%b irq=%b data_o=%h, expected all 0",
                     spi_miso, spi_miso_oe, irq_spi_rx, bus.data_o);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        tick(2);
        for (int a = 0; a < 16; a += 4) begin
            bus_read(a[3:0], d);
            vectors++;
            if (d !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_reg_%0h: got %h expected 00000000", a, d);
            end
        end
    endtask

    task automatic test_mode0();
        logic [31:0] d; logic [7:0] mi, e; int i0;
        bus_write(4'h0, 32'h9);
        set_mode(1'b0, 1'b0);
        bus_write(4'h4, 32'hA5);
        cs_low();
        i0 = irq_cnt;
        miso_q.push_back(8'hA5); rx_q.push_back(8'h3C);
        spi_xfer(8'h3C, 8, mi);
        e = miso_q.pop_front();
        vectors++;
        if (mi !== e) begin miscompares++; $display("FAIL mode0_miso: got %h expected %h", mi, e); end
        bus_read(4'hC, d);
        vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL mode0_status: got %h expected 00000003", d); end
        cs_high();
        vectors++;
        if (irq_cnt - i0 !== 1) begin miscompares++; $display("FAIL mode0_irq: got %0d pulses expected 1", irq_cnt - i0); end
        bus_read(4'h8, d); e = rx_q.pop_front();
        vectors++;
        if (d !== {24'h0, e}) begin miscompares++; $display("FAIL mode0_rxdata: got %h expected %h", d, e); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mov [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] txv [3] = '{8'hB1, 8'hB2, 8'hB3};
        logic [31:0] d; logic [7:0] mi, e; int i0;
        bus_write(4'h0, 32'hF);
        set_mode(1'b1, 1'b1);
        bus_write(4'h4, {24'h0, txv[0]});
        cs_low();
        i0 = irq_cnt;
        for (int k = 0; k < 3; k++) begin
            miso_q.push_back(txv[k]); rx_q.push_back(mov[k]);
            spi_xfer(mov[k], 8, mi);
            e = miso_q.pop_front();
            vectors++;
            if (mi !== e) begin miscompares++; $display("FAIL mode3_miso%0d: got %h expected %h", k, mi, e); end
            vectors++;
            if (irq_cnt - i0 !== k + 1) begin miscompares++; $display("FAIL mode3_irq%0d: got %0d expected %0d", k, irq_cnt - i0, k + 1); end
            bus_read(4'h8, d); e = rx_q.pop_front();
            vectors++;
            if (d !== {24'h0, e}) begin miscompares++; $display("FAIL mode3_rx%0d: got %h expected %h", k, d, e); end
            if (k < 2) bus_write(4'h4, {24'h0, txv[k+1]});
        end
        bus_read(4'hC, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL mode3_status: got %h expected 00000001", d); end
        cs_high();
    endtask

    task automatic test_underrun();
        logic [31:0] d; logic [7:0] mi, e;
        bus_write(4'h0, 32'hD);
        set_mode(1'b0, 1'b1);
        cs_low();
        miso_q.push_back(8'h00); rx_q.push_back(8'hF0);
        spi_xfer(8'hF0, 8, mi);
        e = miso_q.pop_front();
        vectors++;
        if (mi !== e) begin miscompares++; $display("FAIL mode1_miso: got %h expected %h", mi, e); end
        bus_read(4'hC, d);
        vectors++;
        if (d !== 32'h13) begin miscompares++; $display("FAIL mode1_status: got %h expected 00000013", d); end
        cs_high();
        bus_write(4'hC, 32'h10);
        bus_read(4'hC, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL underrun_w1c: got %h expected 00000002", d); end
        bus_read(4'h8, d); e = rx_q.pop_front();
        vectors++;
        if (d !== {24'h0, e}) begin miscompares++; $display("FAIL mode1_rxdata: got %h expected %h", d, e); end
    endtask

    task automatic test_overrun();
        logic [31:0] d; logic [7:0] mi, e;
        bus_write(4'h0, 32'h9);
        set_mode(1'b0, 1'b0);
        cs_low();
        miso_q.push_back(8'h00); miso_q.push_back(8'h00);
        rx_q.push_back(8'hAA);
        spi_xfer(8'h55, 8, mi);
        e = miso_q.pop_front();
        vectors++;
        if (mi !== e) begin miscompares++; $display("FAIL ovr_miso0: got %h expected %h", mi, e); end
        spi_xfer(8'hAA, 8, mi);
        e = miso_q.pop_front();
        vectors++;
        if (mi !== e) begin miscompares++; $display("FAIL ovr_miso1: got %h expected %h", mi, e); end
        bus_read(4'hC, d);
        vectors++;
        if (d !== 32'h1B) begin miscompares++; $display("FAIL ovr_status: got %h expected 0000001b", d); end
        bus_read(4'h8, d); e = rx_q.pop_front();
        vectors++;
        if (d !== {24'h0, e}) begin miscompares++; $display("FAIL ovr_rxdata: got %h expected %h", d, e); end
        cs_high();
        bus_read(4'hC, d);
        vectors++;
        if (d !== 32'h18) begin miscompares++; $display("FAIL ovr_rxvalid_clr: got %h expected 00000018", d); end
        bus_write(4'hC, 32'h18);
        bus_read(4'hC, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL ovr_w1c: got %h expected 00000000", d); end
    endtask

    task automatic test_cs_abort();
        logic [31:0] d; logic [7:0] mi, e; int i0;
        bus_write(4'h0, 32'hB);
        set_mode(1'b1, 1'b0);
        i0 = irq_cnt;
        cs_low();
        spi_xfer(8'hFF, 4, mi);
        cs_high();
        vectors++;
        if (irq_cnt !== i0) begin miscompares++; $display("FAIL abort_irq: got %0d pulses expected 0", irq_cnt - i0); end
        bus_read(4'hC, d);
        vectors++;
        if (d !== 32'h10) begin miscompares++; $display("FAIL abort_status: got %h expected 00000010", d); end
        cs_low();
        miso_q.push_back(8'h00); rx_q.push_back(8'h81);
        spi_xfer(8'h81, 8, mi);
        e = miso_q.pop_front();
        vectors++;
        if (mi !== e) begin miscompares++; $display("FAIL mode2_miso: got %h expected %h", mi, e); end
        cs_high();
        vectors++;
        if (irq_cnt - i0 !== 1) begin miscompares++; $display("FAIL mode2_irq: got %0d pulses expected 1", irq_cnt - i0); end
        bus_read(4'h8, d); e = rx_q.pop_front();
        vectors++;
        if (d !== {24'h0, e}) begin miscompares++; $display("FAIL mode2_rxdata: got %h expected %h", d, e); end
        bus_write(4'hC, 32'h18);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d; logic [7:0] mi, e; int i0;
        bus_write(4'h0, 32'h9);
        set_mode(1'b0, 1'b0);
        bus_write(4'h4, 32'h5A);
        bus_read(4'h4, d);
        vectors++;
        if (d !== 32'h5A) begin miscompares++; $display("FAIL mid_txread: got %h expected 0000005a", d); end
        cs_low();
        spi_xfer(8'hFF, 4, mi);
        vectors++;
        if ({spi_miso, spi_miso_oe} !== 2'b11) begin
            miscompares++; $display("FAIL mid_prereset: got miso=%b oe=%b expected 1 1", spi_miso, spi_miso_oe);
        end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({spi_miso, spi_miso_oe, irq_spi_rx} !== 3'b000 || bus.data_o !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got miso=%b oe=%b irq=%b data_o=%h expected all 0",
                     spi_miso, spi_miso_oe, irq_spi_rx, bus.data_o);
        end
        #3 rst_n = 1'b1;
        cs = 1'b1;
        tick(6);
        for (int a = 0; a < 16; a += 4) begin
            bus_read(a[3:0], d);
            vectors++;
            if (d !== 32'h0) begin miscompares++; $display("FAIL mid_reg_%0h: got %h expected 00000000", a, d); end
        end
        bus_write(4'h0, 32'h9);
        bus_write(4'h4, 32'hC3);
        cs_low();
        i0 = irq_cnt;
        miso_q.push_back(8'hC3); rx_q.push_back(8'h7E);
        spi_xfer(8'h7E, 8, mi);
        e = miso_q.pop_front();
        vectors++;
        if (mi !== e) begin miscompares++; $display("FAIL post_reset_miso: got %h expected %h", mi, e); end
        cs_high();
        vectors++;
        if (irq_cnt - i0 !== 1) begin miscompares++; $display("FAIL post_reset_irq: got %0d pulses expected 1", irq_cnt - i0); end
        bus_read(4'h8, d); e = rx_q.pop_front();
        vectors++;
        if (d !== {24'h0, e}) begin miscompares++; $display("FAIL post_reset_rxdata: got %h expected %h", d, e); end
    endtask

    initial begin
        bus.waddr_i = 8'h0; bus.data_i = 32'h0; bus.sel_i = 4'h0; bus.we_i = 1'b0;
        bus.raddr_i = 8'h0; bus.rd_i = 1'b0;
        test_reset();
        test_mode0();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_cs_abort();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
